// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), 2-flop synchronized input, midpoint sampling.
// Latency: o_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start edge (+CLKS_PER_BIT with parity).
// Backpressure: none; result pulses are single-cycle and cannot be stalled by downstream logic.
module uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_parity_err,
   output logic       o_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   logic [1:0]       sync_q;
   logic             rx_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             done_ok_q, done_ok_d;
   logic             done_ferr_q, done_ferr_d;
   logic [7:0]       data_q;
   logic             valid_q;
   logic             ferr_q;
   logic             busy_q;
`ifdef UART_RX_PARITY_EN
   logic             par_mis_q, par_mis_d;
   logic             done_perr_q, done_perr_d;
   logic             perr_q;
`endif

   // Synchronizer resets to the idle-line level so reset release never looks like a start bit.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], i_rx};
      end
   end

   assign rx_s = sync_q[1];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         done_ok_q   <= 1'b0;
         done_ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_mis_q   <= 1'b0;
         done_perr_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         done_ok_q   <= done_ok_d;
         done_ferr_q <= done_ferr_d;
`ifdef UART_RX_PARITY_EN
         par_mis_q   <= par_mis_d;
         done_perr_q <= done_perr_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      done_ok_d   = 1'b0;
      done_ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_d   = par_mis_q;
      done_perr_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
               par_mis_d = 1'b0;
`endif
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d     = '0;
               par_mis_d = (rx_s != ^shift_q);
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               // Leaving at the stop midpoint leaves half a bit to catch a gapless next start bit.
               if (rx_s) begin
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  done_perr_d = par_mis_q;
                  done_ok_d   = !par_mis_q;
`else
                  done_ok_d   = 1'b1;
`endif
               end else begin
                  state_d     = S_BREAK;
                  done_ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  done_perr_d = par_mis_q;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output stage: results land one cycle after the stop sample, busy is aligned with them.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         if (done_ok_q) begin
            data_q <= shift_q;
         end
         valid_q <= done_ok_q;
         ferr_q  <= done_ferr_q;
         busy_q  <= (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
         perr_q  <= done_perr_q;
`endif
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = perr_q;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; expected events are derived from frame start times and bit values.
module tb_uart_rx;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + PAR * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] o_data;
   logic       o_valid, o_frame_err, o_parity_err, o_busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_rx        (rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_parity_err(o_parity_err),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int kind;   // 1 = valid, 2 = frame error, 3 = parity error
      int data;
   } evt_t;

   evt_t obs_q[$];
   evt_t exp_q[$];
   int   cyc        = 0;
   int   n_tests    = 0;
   int   n_fail     = 0;
   int   viol       = 0;
   int   busy_fall  = -1;
   int   last_good  = 0;
   logic pv = 1'b0, pf = 1'b0, pp = 1'b0, pb = 1'b0;

   function automatic evt_t mk(input int c, input int k, input int d);
      evt_t e;
      e.cyc  = c;
      e.kind = k;
      e.data = d;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         pv <= 1'b0;
         pf <= 1'b0;
         pp <= 1'b0;
         pb <= 1'b0;
      end else begin
         if (o_valid)      obs_q.push_back(mk(cyc, 1, int'(o_data)));
         if (o_frame_err)  obs_q.push_back(mk(cyc, 2, 0));
         if (o_parity_err) obs_q.push_back(mk(cyc, 3, 0));
         if ((o_valid && pv) || (o_frame_err && pf) || (o_parity_err && pp) ||
             (o_valid && (o_frame_err || o_parity_err)))
            viol <= viol + 1;
         if (pb && !o_busy) busy_fall <= cyc;
         pv <= o_valid;
         pf <= o_frame_err;
         pp <= o_parity_err;
         pb <= o_busy;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at a negedge; stop_len cycles of the stop level end the task.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                             input int stop_len, output int t0);
      bit mis;
      t0  = cyc + 1;
      mis = (PAR != 0) && par_flip;
      if (!stop_ok) begin
         exp_q.push_back(mk(t0 + LAT, 2, 0));
         if (mis) exp_q.push_back(mk(t0 + LAT, 3, 0));
      end else if (mis) begin
         exp_q.push_back(mk(t0 + LAT, 3, 0));
      end else begin
         exp_q.push_back(mk(t0 + LAT, 1, int'(b)));
         last_good = int'(b);
      end
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip;
      repeat (CPB) @(negedge clk);
`endif
      rx = stop_ok;
      repeat (stop_len) @(negedge clk);
   endtask

   task automatic compare_events(input string tag);
      check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("%s_cyc%0d", tag, i), obs_q[i].cyc, exp_q[i].cyc);
         check($sformatf("%s_kind%0d", tag, i), obs_q[i].kind, exp_q[i].kind);
         check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2;
      logic [7:0] rb;
      bit ok, flip;

      rx  = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data", o_data, 8'h00);
      check("rst_valid", o_valid, 1'b0);
      check("rst_ferr", o_frame_err, 1'b0);
      check("rst_perr", o_parity_err, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      rx  = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(5);

      send_frame(8'h55, 1'b1, 1'b0, CPB, t0);
      idle(4);
      check("p55_busy_fall", busy_fall, t0 + LAT);
      check("p55_data", o_data, 8'h55);
      compare_events("p55");

      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      check("glitch_busy", o_busy, 1'b0);
      idle(5);
      compare_events("glitch");

      send_frame(8'h3C, 1'b1, 1'b0, CPB, t0);
      idle(3);
      send_frame(8'hA3, 1'b0, 1'b0, 40, t0);
      check("brk_busy", o_busy, 1'b1);
      check("brk_data_held", o_data, 8'h3C);
      idle(8);
      check("brk_exit_busy", o_busy, 1'b0);
      send_frame(8'h12, 1'b1, 1'b0, CPB, t0);
      idle(4);
      check("brk_next_data", o_data, 8'h12);
      compare_events("brk");

      send_frame(8'h00, 1'b1, 1'b0, CPB, t1);
      send_frame(8'hFF, 1'b1, 1'b0, CPB, t2);
      idle(4);
      check("b2b_spacing", obs_q[1].cyc - obs_q[0].cyc, 10 * CPB + PAR * CPB);
      compare_events("b2b");

      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
      rx = 1'b0;
      repeat (2 * CPB + CPB / 2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_data", o_data, 8'h00);
      check("mid_rst_valid", o_valid, 1'b0);
      check("mid_rst_ferr", o_frame_err, 1'b0);
      check("mid_rst_perr", o_parity_err, 1'b0);
      check("mid_rst_busy", o_busy, 1'b0);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      last_good = 0;
      idle(5);
      send_frame(8'hC3, 1'b1, 1'b0, CPB, t0);
      idle(4);
      check("post_rst_data", o_data, 8'hC3);
      compare_events("midrst");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, CPB, t0);
      idle(3);
      send_frame(8'h07, 1'b1, 1'b1, CPB, t0);
      idle(3);
      send_frame(8'hA5, 1'b0, 1'b1, CPB + 8, t0);
      idle(6);
      check("par_data_held", o_data, 8'h07);
      compare_events("par");
`endif

      for (int n = 0; n < 30; n++) begin
         rb   = 8'($urandom);
         ok   = ($urandom_range(0, 5) != 0);
         flip = (PAR != 0) && ($urandom_range(0, 3) == 0);
         if (ok) begin
            send_frame(rb, 1'b1, flip, CPB, t0);
            idle($urandom_range(0, 20));
         end else begin
            send_frame(rb, 1'b0, flip, CPB + $urandom_range(0, 30), t0);
            idle(4 + $urandom_range(0, 10));
         end
      end
      idle(4);
      check("rand_last_data", o_data, 8'(last_good));
      compare_events("rand");

      check("pulse_rules", viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, giving i_clock cycles per UART bit (115200 baud at 12 MHz); legal range 4..65535.
REQ-002 SHALL have port i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_rx  input  1  serial line, asynchronous to i_clock, idle high, 8N1 (8E1 with parity), LSB first.
REQ-005 SHALL have port o_data  output  8  last correctly received byte; holds between frames.
REQ-006 SHALL have port o_valid  output  1  one-cycle pulse when o_data is updated.
REQ-007 SHALL have port o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port o_parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is not compiled in.
REQ-009 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass i_rx through a 2-flop synchronizer; only the synchronized value (rx_s) is used.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (parity builds only), STOP, BREAK.
REQ-012 IDLE: on rx_s==0 -> START, bit counter cleared.
REQ-013 START: sample rx_s when the counter reaches CLKS_PER_BIT/2-1 (integer division); 0 -> DATA with counter cleared and bit index 0; 1 -> IDLE (glitch rejected), no output pulse.
REQ-014 DATA: sample rx_s each time the counter reaches CLKS_PER_BIT-1, then clear the counter; the sample goes into shift bit index 0..7, LSB first; after bit 7 -> PARITY if compiled in, else -> STOP.
REQ-015 PARITY: sample one bit after CLKS_PER_BIT cycles; record a mismatch against even parity of the 8 data bits; -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles, at the stop-bit midpoint.
- 1 with no parity mismatch: o_data <= shift register; o_valid pulses in the next cycle; -> IDLE.
- 1 with parity mismatch: o_parity_err pulses; o_valid stays 0; o_data unchanged; -> IDLE.
- 0: o_frame_err pulses, plus o_parity_err if there is also a mismatch; o_valid stays 0; o_data unchanged; -> BREAK.
REQ-017 BREAK: remain until rx_s==1, then -> IDLE; a line held low never produces further frames.
REQ-018 Returning to IDLE at the stop-bit midpoint SHALL allow a back-to-back start bit with zero idle gap to be received.
REQ-019 Latency, 8N1: o_valid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the first i_clock edge that sees i_rx low; add CLKS_PER_BIT when parity is compiled in.
REQ-020 o_valid, o_frame_err and o_parity_err SHALL be mutually exclusive except the frame+parity combination in REQ-016; each is never high for two consecutive cycles.
REQ-021 Bit counter width SHALL be $clog2(CLKS_PER_BIT); it SHALL not wrap in any state.

Reset
REQ-022 While i_reset is high: state=IDLE; counters=0; o_data=8'h00; o_valid, o_frame_err, o_parity_err = 0; o_busy=0; both synchronizer flops =1 (idle line).
REQ-023 Reset asserted mid-frame SHALL abort the frame with no output pulse; reception resumes at the next falling edge after reset release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: the PARITY state and even-parity checking are present; frame = 11 bits.
REQ-025 Macro UART_RX_PARITY_EN undefined: no PARITY state or parity logic; o_parity_err is tied to 0; frame = 10 bits.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-026 Send 8N1 byte 0x55 -> single o_valid pulse, o_data=0x55, at exactly 2+8+144+1 cycles after the start edge; o_busy falls the same cycle.
REQ-027 Drive i_rx low for 4 cycles, then high -> no o_valid/o_frame_err; o_busy returns low within 10 cycles.
REQ-028 Send 0x3C, then 0xA3 with stop bit 0, held low 40 cycles -> o_frame_err pulse; o_data stays 0x3C; state BREAK until i_rx rises; following 0x12 is received correctly.
REQ-029 Send 0x00 then 0xFF with zero inter-frame gap -> two o_valid pulses carrying 0x00 then 0xFF, 160 cycles apart.
REQ-030 Assert i_reset during data bit 3 of 0x81 -> all outputs 0 with no pulse; the next frame 0xC3 yields o_data=0xC3.
REQ-031 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> o_valid, o_data=0x07; 0x07 with parity bit 0 -> o_parity_err, no o_valid.
